hdp_frame_receiver: RTL

//  Sink end of the HDP panel link. Samples o_lcdData/o_valid/o_update/o_nReset as the panel does.

---
 rtl/hdp_pkg.sv | 22 ++
 rtl/hdp_frame_receiver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/hdp_pkg.sv
// Shared HDP link definitions: receiver state encoding and default panel geometry.
package hdp_pkg;

  typedef enum logic [1:0] {
    s_IDLE,
    s_LINE,
    s_BLANK,
    s_PORCH
  } hdpState_t;

  localparam int unsigned HDP_WORD_W         = 32;
  localparam int unsigned HDP_WORDS_PER_LINE = 40;
  localparam int unsigned HDP_BLANK_CLOCKS   = 4;
  localparam int unsigned HDP_LINES          = 1280;
  localparam int unsigned HDP_PORCH_CLOCKS   = 24;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cntWidth(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hdp_frame_receiver.sv
// Sink end of the HDP panel link: recovers word/line/frame position, emits
// accepted words with coordinates, a per-frame checksum and framing errors.
module hdp_frame_receiver
  import hdp_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = HDP_WORDS_PER_LINE,
  parameter int unsigned BLANK_CLOCKS   = HDP_BLANK_CLOCKS,
  parameter int unsigned LINES          = HDP_LINES,
  parameter int unsigned PORCH_CLOCKS   = HDP_PORCH_CLOCKS
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_nReset,
  input  logic [HDP_WORD_W-1:0] i_lcdData,
  input  logic                  i_valid,
  input  logic                  i_update,
  output logic [HDP_WORD_W-1:0] o_wordData,
  output logic                  o_wordValid,
  output logic [5:0]            o_wordIndex,
  output logic [10:0]           o_lineIndex,
  output logic                  o_frameDone,
  output logic [HDP_WORD_W-1:0] o_frameChecksum,
  output logic [15:0]           o_frameCount,
  output logic                  o_lineError,
  output logic                  o_frameError,
  output logic                  o_active
);

  localparam int unsigned WW = cntWidth(WORDS_PER_LINE);
  localparam int unsigned LW = cntWidth(LINES);
  localparam int unsigned BW = cntWidth(BLANK_CLOCKS);
  localparam int unsigned PW = cntWidth(PORCH_CLOCKS);

  localparam logic [WW-1:0] WORD_LAST  = WW'(WORDS_PER_LINE - 1);
  localparam logic [LW-1:0] LINE_LAST  = LW'(LINES - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CLOCKS - 1);
  localparam logic [PW-1:0] PORCH_LAST = PW'(PORCH_CLOCKS - 1);

  hdpState_t             state;
  logic                  r_updatePrev;
  logic                  start;
  logic [WW-1:0]         wordCnt;
  logic [LW-1:0]         lineCnt;
  logic [BW-1:0]         blankCnt;
  logic [PW-1:0]         porchCnt;
  logic [HDP_WORD_W-1:0] acc;

  always_comb begin
    start = i_update & ~r_updatePrev;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state           <= s_IDLE;
      r_updatePrev    <= 1'b0;
      wordCnt         <= '0;
      lineCnt         <= '0;
      blankCnt        <= '0;
      porchCnt        <= '0;
      acc             <= '0;
      o_wordData      <= '0;
      o_wordValid     <= 1'b0;
      o_wordIndex     <= '0;
      o_lineIndex     <= '0;
      o_frameDone     <= 1'b0;
      o_frameChecksum <= '0;
      o_frameCount    <= '0;
      o_lineError     <= 1'b0;
      o_frameError    <= 1'b0;
      o_active        <= 1'b0;
    end else begin
      r_updatePrev <= i_update;
      o_wordValid  <= 1'b0;
      o_frameDone  <= 1'b0;
      o_lineError  <= 1'b0;
      o_frameError <= 1'b0;

      if (!i_nReset) begin
        o_frameError <= (state != s_IDLE);
        state        <= s_IDLE;
        o_active     <= 1'b0;
      end else if (start) begin
        // A start edge restarts the frame from any state; a word present
        // in the same cycle becomes word 0 of line 0.
        o_frameError <= (state != s_IDLE);
        o_active     <= 1'b1;
        state        <= s_LINE;
        wordCnt      <= '0;
        lineCnt      <= '0;
        blankCnt     <= '0;
        porchCnt     <= '0;
        acc          <= '0;
        if (i_valid) begin
          o_wordData  <= i_lcdData;
          o_wordValid <= 1'b1;
          o_wordIndex <= '0;
          o_lineIndex <= '0;
          acc         <= i_lcdData;
          if (WORD_LAST == '0) state <= s_BLANK;
          else                 wordCnt <= WW'(1);
        end
      end else begin
        unique case (state)
          s_IDLE: ;

          s_LINE: begin
            if (i_valid) begin
              o_wordData  <= i_lcdData;
              o_wordValid <= 1'b1;
              o_wordIndex <= 6'(wordCnt);
              o_lineIndex <= 11'(lineCnt);
              acc         <= acc + i_lcdData;
              if (wordCnt == WORD_LAST) begin
                wordCnt  <= '0;
                blankCnt <= '0;
                state    <= s_BLANK;
              end else begin
                wordCnt <= wordCnt + 1'b1;
              end
            end
          end

          s_BLANK: begin
            if (!i_valid) begin
              if (blankCnt == BLANK_LAST) begin
                blankCnt <= '0;
                if (lineCnt == LINE_LAST) begin
                  porchCnt <= '0;
                  state    <= s_PORCH;
                end else begin
                  lineCnt <= lineCnt + 1'b1;
                  state   <= s_LINE;
                end
              end else begin
                blankCnt <= blankCnt + 1'b1;
              end
            end else if (lineCnt == LINE_LAST) begin
              o_frameError <= 1'b1;
              o_active     <= 1'b0;
              state        <= s_IDLE;
            end else begin
              // Early word: resynchronise on it as word 0 of the next line.
              o_lineError <= 1'b1;
              o_wordData  <= i_lcdData;
              o_wordValid <= 1'b1;
              o_wordIndex <= '0;
              o_lineIndex <= 11'(lineCnt + 1'b1);
              acc         <= acc + i_lcdData;
              lineCnt     <= lineCnt + 1'b1;
              blankCnt    <= '0;
              if (WORD_LAST == '0) begin
                state <= s_BLANK;
              end else begin
                wordCnt <= WW'(1);
                state   <= s_LINE;
              end
            end
          end

          s_PORCH: begin
            if (i_valid) begin
              o_frameError <= 1'b1;
              o_active     <= 1'b0;
              state        <= s_IDLE;
            end else if (porchCnt == PORCH_LAST) begin
              o_frameDone     <= 1'b1;
              o_frameChecksum <= acc;
              o_frameCount    <= o_frameCount + 1'b1;
              o_active        <= 1'b0;
              state           <= s_IDLE;
            end else begin
              porchCnt <= porchCnt + 1'b1;
            end
          end

          default: begin
            o_active <= 1'b0;
            state    <= s_IDLE;
          end
        endcase
      end
    end
  end

endmodule
